// File: rtl/bounce_pkg.sv
// Shared types for the bouncing-box pixel source: axis direction and update FSM state,
// plus the colour-index step used when BOUNCE_SOURCE_COLOR_CYCLE_EN is defined.
package bounce_pkg;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Colour index skips 0 so the box never turns black.
  function automatic logic [2:0] next_colour_idx(input logic [2:0] idx);
    return (idx == 3'd7) ? 3'd1 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/bounce_source_axis_step.sv
// One-axis position step with edge bounce; purely combinational, one instance per axis.
module axis_step
  import bounce_pkg::*;
#(
  parameter int W     = 10,
  parameter int LIMIT = 608,
  parameter int SPEED = 2
) (
  input  logic [W-1:0] pos,
  input  dir_t         dir,
  output logic [W-1:0] next_pos,
  output dir_t         next_dir,
  output logic         flipped
);

  localparam logic [W:0] LIM_E = (W+1)'(LIMIT);
  localparam logic [W:0] SPD_E = (W+1)'(SPEED);

  // One extra bit keeps pos+SPEED from wrapping near the top of the range.
  logic [W:0] sum_s;
  assign sum_s = {1'b0, pos} + SPD_E;

  // Next position and direction for the current travel direction.
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    case (dir)
      DIR_POS: begin
        if (sum_s >= LIM_E) begin
          next_pos = LIM_E[W-1:0];
          next_dir = DIR_NEG;
        end else begin
          next_pos = sum_s[W-1:0];
          next_dir = DIR_POS;
        end
      end
      DIR_NEG: begin
        if ({1'b0, pos} <= SPD_E) begin
          next_pos = {W{1'b0}};
          next_dir = DIR_POS;
        end else begin
          next_pos = pos - SPD_E[W-1:0];
          next_dir = DIR_NEG;
        end
      end
      default: begin
        next_pos = pos;
        next_dir = DIR_POS;
      end
    endcase
    flipped = (next_dir != dir);
  end

endmodule

// File: rtl/bounce_source.sv
// Bouncing box over a checkerboard for the VGA pipeline; one position update per FRAME_DIV frames.
// Optional feature: BOUNCE_SOURCE_COLOR_CYCLE_EN cycles the box colour on every bounce.
module bounce_source
  import bounce_pkg::*;
#(
  parameter int COL_BITS  = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 10,
  parameter int BOX_W     = 32,
  parameter int BOX_H     = 32,
  parameter int SPEED     = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_frame,
  input  logic                i_active,
  input  logic [X_BITS-1:0]   i_x,
  input  logic [Y_BITS-1:0]   i_y,
  output logic [COL_BITS-1:0] o_r,
  output logic [COL_BITS-1:0] o_g,
  output logic [COL_BITS-1:0] o_b,
  output logic                o_bounce
);

  localparam int FCNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FCNT_W-1:0]   FCNT_MAX = FCNT_W'(FRAME_DIV - 1);
  localparam logic [X_BITS:0]     BOX_W_E  = (X_BITS+1)'(BOX_W);
  localparam logic [Y_BITS:0]     BOX_H_E  = (Y_BITS+1)'(BOX_H);
  localparam logic [COL_BITS-1:0] BLACK    = {COL_BITS{1'b0}};
  localparam logic [COL_BITS-1:0] CHK_HI   = COL_BITS'(1) << (COL_BITS - 1);
  localparam logic [COL_BITS-1:0] CHK_LO   = COL_BITS'(1) << (COL_BITS - 2);

  state_t              state_r;
  logic [FCNT_W-1:0]   fcnt_r;
  logic [X_BITS-1:0]   box_x_r, nx_r;
  logic [Y_BITS-1:0]   box_y_r, ny_r;
  dir_t                dir_x_r, dir_y_r, ndx_r, ndy_r;
  logic                fx_r, fy_r;

  logic [X_BITS-1:0]   step_x_pos_s;
  logic [Y_BITS-1:0]   step_y_pos_s;
  dir_t                step_x_dir_s, step_y_dir_s;
  logic                step_x_flip_s, step_y_flip_s;

  axis_step #(.W(X_BITS), .LIMIT(H_RES - BOX_W), .SPEED(SPEED)) u_step_x (
    .pos      (box_x_r),
    .dir      (dir_x_r),
    .next_pos (step_x_pos_s),
    .next_dir (step_x_dir_s),
    .flipped  (step_x_flip_s)
  );

  axis_step #(.W(Y_BITS), .LIMIT(V_RES - BOX_H), .SPEED(SPEED)) u_step_y (
    .pos      (box_y_r),
    .dir      (dir_y_r),
    .next_pos (step_y_pos_s),
    .next_dir (step_y_dir_s),
    .flipped  (step_y_flip_s)
  );

  // Update FSM: working registers stay private until COMMIT so rendering never sees half a move.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= IDLE;
      fcnt_r   <= {FCNT_W{1'b0}};
      box_x_r  <= {X_BITS{1'b0}};
      box_y_r  <= {Y_BITS{1'b0}};
      dir_x_r  <= DIR_POS;
      dir_y_r  <= DIR_POS;
      nx_r     <= {X_BITS{1'b0}};
      ny_r     <= {Y_BITS{1'b0}};
      ndx_r    <= DIR_POS;
      ndy_r    <= DIR_POS;
      fx_r     <= 1'b0;
      fy_r     <= 1'b0;
      o_bounce <= 1'b0;
    end else begin
      o_bounce <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_en && i_frame) begin
            if (fcnt_r == FCNT_MAX) begin
              fcnt_r  <= {FCNT_W{1'b0}};
              state_r <= STEP_X;
            end else begin
              fcnt_r  <= fcnt_r + FCNT_W'(1);
            end
          end
        end
        STEP_X: begin
          nx_r    <= step_x_pos_s;
          ndx_r   <= step_x_dir_s;
          fx_r    <= step_x_flip_s;
          state_r <= STEP_Y;
        end
        STEP_Y: begin
          ny_r    <= step_y_pos_s;
          ndy_r   <= step_y_dir_s;
          fy_r    <= step_y_flip_s;
          state_r <= COMMIT;
        end
        COMMIT: begin
          box_x_r  <= nx_r;
          box_y_r  <= ny_r;
          dir_x_r  <= ndx_r;
          dir_y_r  <= ndy_r;
          o_bounce <= fx_r | fy_r;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  logic [COL_BITS-1:0] box_r_s, box_g_s, box_b_s;

`ifdef BOUNCE_SOURCE_COLOR_CYCLE_EN
  logic [2:0] idx_r;

  // Colour index advances once per bouncing commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_r <= 3'd1;
    end else if ((state_r == COMMIT) && (fx_r || fy_r)) begin
      idx_r <= next_colour_idx(idx_r);
    end else begin
      idx_r <= idx_r;
    end
  end

  assign box_r_s = {COL_BITS{idx_r[2]}};
  assign box_g_s = {COL_BITS{idx_r[1]}};
  assign box_b_s = {COL_BITS{idx_r[0]}};
`else
  assign box_r_s = {COL_BITS{1'b1}};
  assign box_g_s = {COL_BITS{1'b1}};
  assign box_b_s = {COL_BITS{1'b1}};
`endif

  logic in_box_s;
  assign in_box_s = ({1'b0, i_x} >= {1'b0, box_x_r}) &&
                    ({1'b0, i_x} <  ({1'b0, box_x_r} + BOX_W_E)) &&
                    ({1'b0, i_y} >= {1'b0, box_y_r}) &&
                    ({1'b0, i_y} <  ({1'b0, box_y_r} + BOX_H_E));

  logic [COL_BITS-1:0] pix_r_s, pix_g_s, pix_b_s;

  // Pixel colour priority: blanked/disabled, then box, then checkerboard.
  always_comb begin
    pix_r_s = BLACK;
    pix_g_s = BLACK;
    pix_b_s = BLACK;
    if (!(i_en && i_active)) begin
      pix_r_s = BLACK;
      pix_g_s = BLACK;
      pix_b_s = BLACK;
    end else if (in_box_s) begin
      pix_r_s = box_r_s;
      pix_g_s = box_g_s;
      pix_b_s = box_b_s;
    end else if (i_x[4] ^ i_y[4]) begin
      pix_r_s = CHK_HI;
      pix_g_s = CHK_HI;
      pix_b_s = CHK_HI;
    end else begin
      pix_r_s = CHK_LO;
      pix_g_s = CHK_LO;
      pix_b_s = CHK_LO;
    end
  end

  // One-cycle registered colour output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_r <= BLACK;
      o_g <= BLACK;
      o_b <= BLACK;
    end else begin
      o_r <= pix_r_s;
      o_g <= pix_g_s;
      o_b <= pix_b_s;
    end
  end

endmodule

// File: tb/tb_bounce_source.sv
// Directed bench for bounce_source: default build, a 64x64 instance and a FRAME_DIV=3 instance.
module tb_bounce_source;

  logic       clk = 1'b0;
  logic       rst, en, active;
  logic [9:0] x, y;
  logic [2:0] frm;

  logic [3:0] r_a, g_a, b_a, r_s, g_s, b_s, r_d, g_d, b_d;
  logic       bnc_a, bnc_s, bnc_d;

  int n_checks = 0;
  int n_fail   = 0;
  int bc_a = 0, bc_s = 0, bc_d = 0;

  always #5 clk = ~clk;

  bounce_source dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_frame(frm[0]), .i_active(active),
    .i_x(x), .i_y(y), .o_r(r_a), .o_g(g_a), .o_b(b_a), .o_bounce(bnc_a)
  );

  bounce_source #(.H_RES(64), .V_RES(64), .BOX_W(16), .BOX_H(16)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_frame(frm[1]), .i_active(active),
    .i_x(x), .i_y(y), .o_r(r_s), .o_g(g_s), .o_b(b_s), .o_bounce(bnc_s)
  );

  bounce_source #(.FRAME_DIV(3)) dut_d (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_frame(frm[2]), .i_active(active),
    .i_x(x), .i_y(y), .o_r(r_d), .o_g(g_d), .o_b(b_d), .o_bounce(bnc_d)
  );

  // Bounce pulses counted on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (bnc_a) bc_a++;
    if (bnc_s) bc_s++;
    if (bnc_d) bc_d++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a coordinate, then land on the falling edge where its colour is registered.
  task automatic probe(input int px, input int py, input logic act);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    active = act;
    @(negedge clk);
  endtask

  // n single-cycle frame pulses to one instance, each followed by enough idle for the commit.
  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frm[which] = 1'b1;
      @(negedge clk);
      frm[which] = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; active = 1'b1; x = 10'd0; y = 10'd0; frm = 3'd0;
    repeat (3) @(negedge clk);
    check_value("reset_rgb", {r_a, g_a, b_a}, 32'h000);
    check_value("reset_bounce", bnc_a, 32'h0);
    rst = 1'b0;

    probe(0, 0, 1'b1);    check_value("box_00", {r_a, g_a, b_a}, 32'hFFF);
    probe(5, 20, 1'b1);   check_value("box_5_20", {r_a, g_a, b_a}, 32'hFFF);
    probe(40, 40, 1'b1);  check_value("chk_dark", {r_a, g_a, b_a}, 32'h444);
    probe(16, 40, 1'b1);  check_value("chk_light", {r_a, g_a, b_a}, 32'h888);
    probe(5, 5, 1'b0);    check_value("inactive", {r_a, g_a, b_a}, 32'h000);

    en = 1'b0;
    probe(5, 5, 1'b1);    check_value("en_off_black", {r_a, g_a, b_a}, 32'h000);
    pulse(0, 1);
    en = 1'b1;
    probe(0, 0, 1'b1);    check_value("en_off_no_move", {r_a, g_a, b_a}, 32'hFFF);

    pulse(0, 1);
    probe(1, 1, 1'b1);    check_value("step1_11", {r_a, g_a, b_a}, 32'h444);
    probe(2, 2, 1'b1);    check_value("step1_22", {r_a, g_a, b_a}, 32'hFFF);
    check_value("step1_no_bounce", bc_a, 32'd0);

    // Second pulse lands while the FSM is in STEP_X and must be dropped.
    @(negedge clk); frm[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); frm[0] = 1'b0;
    repeat (4) @(negedge clk);
    probe(3, 3, 1'b1);    check_value("drop_33", {r_a, g_a, b_a}, 32'h444);
    probe(4, 4, 1'b1);    check_value("drop_44", {r_a, g_a, b_a}, 32'hFFF);

    // 304 updates total: x hits 608 (bounce), y bounced at 448 on update 224 and is back at 288.
    pulse(0, 302);
    check_value("f304_bounces", bc_a, 32'd2);
    probe(608, 288, 1'b1); check_value("f304_box", {r_a, g_a, b_a}, 32'hFFF);
    probe(607, 288, 1'b1); check_value("f304_left", {r_a, g_a, b_a}, 32'h888);
    pulse(0, 1);
    check_value("f305_bounces", bc_a, 32'd2);
    probe(606, 286, 1'b1); check_value("f305_box", {r_a, g_a, b_a}, 32'hFFF);
    probe(605, 286, 1'b1); check_value("f305_left", {r_a, g_a, b_a}, 32'h444);

    pulse(2, 2);
    probe(0, 0, 1'b1);    check_value("fdiv_hold", {r_d, g_d, b_d}, 32'hFFF);
    pulse(2, 1);
    probe(1, 1, 1'b1);    check_value("fdiv_11", {r_d, g_d, b_d}, 32'h444);
    probe(2, 2, 1'b1);    check_value("fdiv_22", {r_d, g_d, b_d}, 32'hFFF);
    check_value("fdiv_no_bounce", bc_d, 32'd0);

    pulse(1, 23);
    probe(46, 46, 1'b1);  check_value("small_46", {r_s, g_s, b_s}, 32'hFFF);
    check_value("small_no_bounce", bc_s, 32'd0);
    @(negedge clk); frm[1] = 1'b1;
    @(negedge clk); frm[1] = 1'b0;
    @(negedge clk); check_value("small_bnc_p1", bnc_s, 32'h0);
    @(negedge clk); check_value("small_bnc_p2", bnc_s, 32'h0);
    @(negedge clk); check_value("small_bnc_commit", bnc_s, 32'h1);
    @(negedge clk); check_value("small_bnc_after", bnc_s, 32'h0);
    probe(48, 48, 1'b1);  check_value("small_48", {r_s, g_s, b_s}, 32'hFFF);
    probe(47, 47, 1'b1);  check_value("small_47", {r_s, g_s, b_s}, 32'h444);
    check_value("small_one_bounce", bc_s, 32'd1);
    pulse(1, 1);
    probe(46, 46, 1'b1);  check_value("small_back_46", {r_s, g_s, b_s}, 32'hFFF);
    probe(62, 62, 1'b1);  check_value("small_back_62", {r_s, g_s, b_s}, 32'h444);
    check_value("small_bounce_total", bc_s, 32'd1);

    // Reset sampled while dut_a is in STEP_Y.
    @(negedge clk); frm[0] = 1'b1;
    @(negedge clk); frm[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_value("rst_mid_rgb", {r_a, g_a, b_a}, 32'h000);
    check_value("rst_mid_bounce", bnc_a, 32'h0);
    repeat (4) @(negedge clk);
    check_value("rst_mid_no_commit", bc_a, 32'd2);
    probe(0, 0, 1'b1);    check_value("rst_mid_home", {r_a, g_a, b_a}, 32'hFFF);
    pulse(0, 1);
    probe(2, 2, 1'b1);    check_value("rst_mid_dir_22", {r_a, g_a, b_a}, 32'hFFF);
    probe(1, 1, 1'b1);    check_value("rst_mid_dir_11", {r_a, g_a, b_a}, 32'h444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
